// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame geometry, line level
// and the transmitter FSM state type.
package uart_tx_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A zero baud setting would never produce a terminal count, so it is
  // promoted to the fastest legal rate of one clock per bit.
  function automatic logic [31:0] sanitize_period(input logic [31:0] baud);
    return (baud == 32'd0) ? 32'd1 : baud;
  endfunction

endpackage

// File: rtl/uart_tx_block_timer.sv
// Bit-period timer for the transmitter; same shape as the receive-side timer.
// Counts 0..bit_period-1 and flags the terminal count.
module tx_bit_timer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic [31:0] bit_period,
  output logic        bit_done
);

  logic [31:0] count_r;

  // Terminal count; bit_period is never zero here, so the subtraction is safe.
  assign bit_done = (count_r == (bit_period - 32'd1));

  // Free-running count that restarts on clear or at the end of each bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= 32'd0;
    end else if (clear || bit_done) begin
      count_r <= 32'd0;
    end else begin
      count_r <= count_r + 32'd1;
    end
  end

endmodule

// File: rtl/uart_tx_block.sv
// 8N1 UART transmitter with a one-entry holding buffer so that software can
// queue the next byte while the current frame is on the line.
module uart_tx_block
  import uart_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  tx_data,
  input  logic        data_load,
  input  logic        error_clear,
  input  logic [31:0] baudData,
  output logic        serial_out,
  output logic        tx_busy,
  output logic        buffer_empty,
  output logic        overrun_error
);

  tx_state_t                state_r;
  tx_state_t                state_next_s;
  logic [DATA_BITS-1:0]     hold_r;
  logic                     buf_empty_r;
  logic [DATA_BITS-1:0]     shift_r;
  logic [2:0]               bit_idx_r;
  logic [31:0]              bit_period_r;
  logic                     serial_out_r;
  logic                     tx_busy_r;
  logic                     overrun_r;
  logic                     transfer_s;
  logic                     bit_done_s;
  logic                     timer_clear_s;
  logic                     overrun_set_s;

  tx_bit_timer u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (timer_clear_s),
    .bit_period (bit_period_r),
    .bit_done   (bit_done_s)
  );

  // Next-state decode; a transfer is the only way into START.
  always_comb begin
    state_next_s = state_r;
    transfer_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!buf_empty_r) begin
          transfer_s   = 1'b1;
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (bit_done_s && (bit_idx_r == 3'(DATA_BITS - 1))) begin
          state_next_s = STOP;
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          if (!buf_empty_r) begin
            // Back-to-back: next start bit follows this stop bit directly.
            transfer_s   = 1'b1;
            state_next_s = START;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Timer restarts on every state entry and is held at zero while idle.
  assign timer_clear_s = (state_r == IDLE) || (state_next_s != state_r);

  // A load into a full buffer is lost unless the buffer drains this cycle.
  assign overrun_set_s = data_load && !buf_empty_r && !transfer_s;

  // State register plus registered busy flag derived from the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      tx_busy_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      tx_busy_r <= (state_next_s != IDLE);
    end
  end

  // Shift register, bit index and per-frame bit period.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_r      <= '0;
      bit_idx_r    <= 3'd0;
      bit_period_r <= 32'd1;
    end else if (transfer_s) begin
      shift_r      <= hold_r;
      bit_idx_r    <= 3'd0;
      bit_period_r <= sanitize_period(baudData);
    end else if ((state_r == DATA) && bit_done_s) begin
      shift_r      <= {1'b0, shift_r[DATA_BITS-1:1]};
      bit_idx_r    <= bit_idx_r + 3'd1;
    end else begin
      shift_r      <= shift_r;
      bit_idx_r    <= bit_idx_r;
      bit_period_r <= bit_period_r;
    end
  end

  // Holding buffer; a load coinciding with a transfer refills it at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_r      <= '0;
      buf_empty_r <= 1'b1;
    end else if (transfer_s) begin
      buf_empty_r <= !data_load;
      if (data_load) begin
        hold_r <= tx_data;
      end else begin
        hold_r <= hold_r;
      end
    end else if (data_load && buf_empty_r) begin
      hold_r      <= tx_data;
      buf_empty_r <= 1'b0;
    end else begin
      hold_r      <= hold_r;
      buf_empty_r <= buf_empty_r;
    end
  end

  // Sticky overrun flag; a new overrun outranks a simultaneous clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else if (error_clear) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Registered line driver, one stage behind the state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      serial_out_r <= IDLE_LEVEL;
    end else begin
      case (state_r)
        IDLE:    serial_out_r <= IDLE_LEVEL;
        START:   serial_out_r <= ~IDLE_LEVEL;
        DATA:    serial_out_r <= shift_r[0];
        STOP:    serial_out_r <= IDLE_LEVEL;
        default: serial_out_r <= IDLE_LEVEL;
      endcase
    end
  end

  assign serial_out    = serial_out_r;
  assign tx_busy       = tx_busy_r;
  assign buffer_empty  = buf_empty_r;
  assign overrun_error = overrun_r;

endmodule

// File: tb/tb_uart_tx_block.sv
// Self-checking bench for uart_tx_block. Every sample is taken 1 time unit
// after a rising edge; expected line waveforms come from the frame rules.
module tb_uart_tx_block;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        data_load = 1'b0;
  logic        error_clear = 1'b0;
  logic [31:0] baudData = 32'd1;
  logic        serial_out, tx_busy, buffer_empty, overrun_error;

  int checks = 0;
  int errors = 0;

  logic obs_line[$];
  logic obs_busy[$];
  logic obs_empty[$];
  logic obs_ovr[$];
  logic exp_line[$];

  uart_tx_block dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_data       (tx_data),
    .data_load     (data_load),
    .error_clear   (error_clear),
    .baudData      (baudData),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy),
    .buffer_empty  (buffer_empty),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  task automatic clear_logs();
    obs_line.delete(); obs_busy.delete(); obs_empty.delete(); obs_ovr.delete();
    exp_line.delete();
  endtask

  task automatic record();
    obs_line.push_back(serial_out);
    obs_busy.push_back(tx_busy);
    obs_empty.push_back(buffer_empty);
    obs_ovr.push_back(overrun_error);
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      record();
    end
  endtask

  task automatic load(input logic [7:0] b);
    tx_data = b; data_load = 1'b1;
    @(posedge clk); #1;
    record();
    data_load = 1'b0;
  endtask

  // Reference model: idle line is high.
  task automatic exp_idle(input int n);
    repeat (n) exp_line.push_back(1'b1);
  endtask

  // Reference model: start bit, 8 data bits LSB first, stop bit, p cycles each.
  task automatic exp_frame(input logic [7:0] b, input int p);
    for (int k = 0; k < 10; k++) begin
      logic lv;
      if (k == 0) lv = 1'b0;
      else if (k == 9) lv = 1'b1;
      else lv = b[k-1];
      repeat (p) exp_line.push_back(lv);
    end
  endtask

  task automatic exp_pad();
    while (exp_line.size() < obs_line.size()) exp_line.push_back(1'b1);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_line got %b expected 1", serial_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", tx_busy); end
    checks++; if (buffer_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", buffer_empty); end
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b expected 0", overrun_error); end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_byte();
    int nb = 0;
    int first_low = -1;
    clear_logs(); baudData = 32'd10;
    load(8'hA5); capture(105);
    exp_idle(2); exp_frame(8'hA5, 10); exp_pad();
    for (int i = 0; i < obs_line.size(); i++) begin
      checks++;
      if (obs_line[i] !== exp_line[i]) begin errors++; $display("FAIL single_line[%0d] got %b expected %b", i, obs_line[i], exp_line[i]); end
      if (obs_busy[i] === 1'b1) nb++;
      if (first_low < 0 && obs_line[i] === 1'b0) first_low = i;
    end
    checks++; if (first_low != 2) begin errors++; $display("FAIL single_latency got %0d expected 2", first_low); end
    checks++; if (nb != 100) begin errors++; $display("FAIL single_busy_cycles got %0d expected 100", nb); end
    checks++; if (obs_busy[101] !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b expected 0", obs_busy[101]); end
    checks++; if (obs_empty[0] !== 1'b0) begin errors++; $display("FAIL single_empty_load got %b expected 0", obs_empty[0]); end
    checks++; if (obs_empty[1] !== 1'b1) begin errors++; $display("FAIL single_empty_xfer got %b expected 1", obs_empty[1]); end
  endtask

  task automatic test_back_to_back();
    int bad_empty = 0;
    int ovr_seen = 0;
    clear_logs(); baudData = 32'd4;
    load(8'h00); capture(10); load(8'hFF); capture(75);
    exp_idle(2); exp_frame(8'h00, 4); exp_frame(8'hFF, 4); exp_pad();
    for (int i = 0; i < obs_line.size(); i++) begin
      checks++;
      if (obs_line[i] !== exp_line[i]) begin errors++; $display("FAIL b2b_line[%0d] got %b expected %b", i, obs_line[i], exp_line[i]); end
      if (i >= 11 && i <= 40 && obs_empty[i] !== 1'b0) bad_empty++;
      if (obs_ovr[i] !== 1'b0) ovr_seen++;
    end
    checks++; if (bad_empty != 0) begin errors++; $display("FAIL b2b_empty_held got %0d early frees expected 0", bad_empty); end
    checks++; if (obs_empty[41] !== 1'b1) begin errors++; $display("FAIL b2b_empty_xfer got %b expected 1", obs_empty[41]); end
    checks++; if (ovr_seen != 0) begin errors++; $display("FAIL b2b_overrun got %0d cycles expected 0", ovr_seen); end
  endtask

  task automatic test_overrun();
    clear_logs(); baudData = 32'd3;
    load(8'h11); load(8'h22); load(8'h33); capture(64);
    exp_idle(2); exp_frame(8'h11, 3); exp_frame(8'h22, 3); exp_pad();
    for (int i = 0; i < obs_line.size(); i++) begin
      checks++;
      if (obs_line[i] !== exp_line[i]) begin errors++; $display("FAIL ovr_line[%0d] got %b expected %b", i, obs_line[i], exp_line[i]); end
    end
    checks++; if (obs_ovr[1] !== 1'b0) begin errors++; $display("FAIL ovr_on_xfer got %b expected 0", obs_ovr[1]); end
    checks++; if (obs_ovr[2] !== 1'b1) begin errors++; $display("FAIL ovr_set got %b expected 1", obs_ovr[2]); end
    checks++; if (obs_ovr[66] !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b expected 1", obs_ovr[66]); end
    checks++; if (obs_empty[2] !== 1'b0) begin errors++; $display("FAIL ovr_buf_full got %b expected 0", obs_empty[2]); end
    error_clear = 1'b1;
    @(posedge clk); #1;
    error_clear = 1'b0;
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b expected 0", overrun_error); end
  endtask

  task automatic test_baud_change();
    logic [7:0] b1, b2, b3;
    int nb = 0;
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    clear_logs(); baudData = 32'd8;
    load(b1); capture(20);
    baudData = 32'd3;
    load(b2); capture(110);
    exp_idle(2); exp_frame(b1, 8); exp_frame(b2, 3); exp_pad();
    for (int i = 0; i < obs_line.size(); i++) begin
      checks++;
      if (obs_line[i] !== exp_line[i]) begin errors++; $display("FAIL baud_line[%0d] got %b expected %b", i, obs_line[i], exp_line[i]); end
    end
    clear_logs(); baudData = 32'd0;
    load(b3); capture(15);
    exp_idle(2); exp_frame(b3, 1); exp_pad();
    for (int i = 0; i < obs_line.size(); i++) begin
      checks++;
      if (obs_line[i] !== exp_line[i]) begin errors++; $display("FAIL baud0_line[%0d] got %b expected %b", i, obs_line[i], exp_line[i]); end
      if (obs_busy[i] === 1'b1) nb++;
    end
    checks++; if (nb != 10) begin errors++; $display("FAIL baud0_busy_cycles got %0d expected 10", nb); end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 8; it++) begin
      int p, last;
      logic [7:0] b1, b2;
      logic chain;
      p = int'($urandom_range(1, 6));
      b1 = 8'($urandom); b2 = 8'($urandom);
      chain = 1'($urandom_range(0, 1));
      clear_logs(); baudData = 32'(p);
      load(b1);
      exp_idle(2); exp_frame(b1, p);
      if (chain) begin
        int l;
        l = int'($urandom_range(2, 10 * p));
        capture(l - 1); load(b2); capture(20 * p + 6 - l);
        exp_frame(b2, p);
      end else begin
        capture(10 * p + 4);
      end
      exp_pad();
      for (int i = 0; i < obs_line.size(); i++) begin
        checks++;
        if (obs_line[i] !== exp_line[i]) begin errors++; $display("FAIL rand%0d_line[%0d] got %b expected %b", it, i, obs_line[i], exp_line[i]); end
      end
      last = obs_line.size() - 1;
      checks++; if (obs_busy[last] !== 1'b0 || obs_empty[last] !== 1'b1 || obs_ovr[last] !== 1'b0) begin
        errors++; $display("FAIL rand%0d_end busy/empty/ovr got %b%b%b expected 010", it, obs_busy[last], obs_empty[last], obs_ovr[last]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int nb = 0;
    b = 8'($urandom) & 8'hF7;
    clear_logs(); baudData = 32'd5;
    load(b); capture(9); load(8'($urandom)); capture(12);
    checks++; if (obs_line[22] !== 1'b0) begin errors++; $display("FAIL rst_pre_line got %b expected 0", obs_line[22]); end
    checks++; if (obs_empty[22] !== 1'b0) begin errors++; $display("FAIL rst_pre_buf got %b expected 0", obs_empty[22]); end
    #1 n_rst = 1'b0;
    #1;
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL rst_mid_line got %b expected 1", serial_out); end
    checks++; if (buffer_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got %b expected 1", buffer_empty); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", tx_busy); end
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    clear_logs();
    capture(3); load(8'h5A); capture(60);
    exp_idle(5); exp_frame(8'h5A, 5); exp_pad();
    for (int i = 0; i < obs_line.size(); i++) begin
      checks++;
      if (obs_line[i] !== exp_line[i]) begin errors++; $display("FAIL rst_after_line[%0d] got %b expected %b", i, obs_line[i], exp_line[i]); end
      if (obs_busy[i] === 1'b1) nb++;
    end
    checks++; if (nb != 50) begin errors++; $display("FAIL rst_after_busy_cycles got %0d expected 50", nb); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_baud_change();
    test_random_frames();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
